// File: rtl/wb_stage_if.sv
// wb_stage_if: bundle between the memory stage, data memory, register file
// and the writeback stage.
//   slave  : writeback stage side (consumes retiring instr + load response,
//            drives stall and the register-file write bundle)
//   master : surrounding pipeline side
interface wb_stage_if #(parameter int DATA_WIDTH = 32);
    logic                  valid_in;
    logic                  rf_en_in;
    logic [4:0]            rd_in;
    logic [1:0]            wb_sel_in;
    logic [2:0]            funct3_in;
    logic [DATA_WIDTH-1:0] alu_res_in;
    logic [DATA_WIDTH-1:0] pc4_in;
    logic                  dm_rsp_valid;
    logic [DATA_WIDTH-1:0] dm_rsp_data;
    logic                  stall_out;
    logic                  rf_en;
    logic [4:0]            rd;
    logic [DATA_WIDTH-1:0] wb_data;

    modport slave (
        input  valid_in, rf_en_in, rd_in, wb_sel_in, funct3_in,
               alu_res_in, pc4_in, dm_rsp_valid, dm_rsp_data,
        output stall_out, rf_en, rd, wb_data
    );

    modport master (
        output valid_in, rf_en_in, rd_in, wb_sel_in, funct3_in,
               alu_res_in, pc4_in, dm_rsp_valid, dm_rsp_data,
        input  stall_out, rf_en, rd, wb_data
    );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: RV32I writeback stage.
// Retires instructions from the memory stage, waits for variable-latency
// load responses, aligns/sign-extends load data and drives a registered
// register-file write (rf_en/rd/wb_data). stall_out is combinational and
// freezes upstream while a load response is outstanding.
// Ports:
//   clk, arst  : clock, asynchronous active-high reset
//   bus        : wb_stage_if.slave (retire inputs, dm response, rf write, stall)
//   retire_cnt : 64-bit retired-instruction counter, only when the macro
//                WB_RETIRE_CNT_EN is defined
module wb_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic      clk,
    input  logic      arst,
    wb_stage_if.slave bus
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [63:0] retire_cnt
`endif
);

    typedef enum logic {IDLE, WAIT_LD} state_t;

    state_t                state;
    logic                  rf_en_q;
    logic [4:0]            rd_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [4:0]            cap_rd;
    logic                  cap_en;
    logic [2:0]            cap_f3;
    logic [1:0]            cap_off;

    logic                  waiting;
    logic                  is_load;
    logic                  commit;
    logic [4:0]            c_rd;
    logic                  c_en;
    logic [DATA_WIDTH-1:0] c_data;

    // Byte lanes use both offset bits; halfwords only bit 1.
    function automatic logic [DATA_WIDTH-1:0] fmt_load(
        input logic [DATA_WIDTH-1:0] w,
        input logic [2:0]            f3,
        input logic [1:0]            off
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  fmt_load = {{24{b[7]}}, b};
            3'b001:  fmt_load = {{16{h[15]}}, h};
            3'b100:  fmt_load = {24'd0, b};
            3'b101:  fmt_load = {16'd0, h};
            default: fmt_load = w;
        endcase
    endfunction

    assign waiting = (state == WAIT_LD);
    assign is_load = (bus.wb_sel_in == 2'd1);

    // In WAIT_LD everything but the response is ignored.
    assign commit = waiting ? bus.dm_rsp_valid
                            : (bus.valid_in && (!is_load || bus.dm_rsp_valid));

    always_comb begin
        c_rd   = waiting ? cap_rd : bus.rd_in;
        c_en   = waiting ? cap_en : bus.rf_en_in;
        c_data = bus.alu_res_in;
        if (waiting)
            c_data = fmt_load(bus.dm_rsp_data, cap_f3, cap_off);
        else if (is_load)
            c_data = fmt_load(bus.dm_rsp_data, bus.funct3_in, bus.alu_res_in[1:0]);
        else if (bus.wb_sel_in == 2'd2)
            c_data = bus.pc4_in;
    end

    // Reset forces stall low even if a load is presented during reset.
    assign bus.stall_out = !arst &&
        (waiting ? !bus.dm_rsp_valid
                 : (bus.valid_in && is_load && !bus.dm_rsp_valid));

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state   <= IDLE;
            rf_en_q <= 1'b0;
            rd_q    <= '0;
            data_q  <= '0;
            cap_rd  <= '0;
            cap_en  <= 1'b0;
            cap_f3  <= '0;
            cap_off <= '0;
        end else begin
            // x0 writes are dropped here so the register file never sees them.
            rf_en_q <= commit && c_en && (c_rd != 5'd0);
            if (commit) begin
                rd_q   <= c_rd;
                data_q <= c_data;
            end
            case (state)
                IDLE: begin
                    if (bus.valid_in && is_load && !bus.dm_rsp_valid) begin
                        cap_rd  <= bus.rd_in;
                        cap_en  <= bus.rf_en_in;
                        cap_f3  <= bus.funct3_in;
                        cap_off <= bus.alu_res_in[1:0];
                        state   <= WAIT_LD;
                    end
                end
                WAIT_LD: begin
                    if (bus.dm_rsp_valid)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rf_en   = rf_en_q;
    assign bus.rd      = rd_q;
    assign bus.wb_data = data_q;

`ifdef WB_RETIRE_CNT_EN
    // Counts one cycle behind the rf write, so it trails commit by a cycle.
    logic commit_q;
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            commit_q   <= 1'b0;
            retire_cnt <= '0;
        end else begin
            commit_q   <= commit;
            retire_cnt <= retire_cnt + {63'd0, commit_q};
        end
    end
`endif

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
    logic clk  = 1'b0;
    logic arst = 1'b1;
    always #5 clk = ~clk;

    wb_stage_if #(.DATA_WIDTH(32)) bus ();
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt;
`endif

    wb_stage #(.DATA_WIDTH(32)) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retire_cnt (retire_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0] rd;
        logic       en;
        logic [2:0] f3;
        logic [1:0] off;
    } ld_t;

    ld_t     pend[$];      // loads awaiting a response
    longint  model_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Load result from plain shift/mask arithmetic.
    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] off);
        longint v;
        case (f3)
            3'd0, 3'd4: v = (w >> (8 * off)) & 32'hFF;
            3'd1, 3'd5: v = (w >> (16 * off[1])) & 32'hFFFF;
            default:    return w;
        endcase
        if (f3 == 3'd0 && v >= 128)   v -= 256;
        if (f3 == 3'd1 && v >= 32768) v -= 65536;
        return v[31:0];
    endfunction

    task automatic set_in(input logic v, input logic en, input logic [4:0] rd,
                          input logic [1:0] sel, input logic [2:0] f3,
                          input logic [31:0] alu, input logic [31:0] pc4,
                          input logic rv, input logic [31:0] rdat);
        bus.valid_in     = v;
        bus.rf_en_in     = en;
        bus.rd_in        = rd;
        bus.wb_sel_in    = sel;
        bus.funct3_in    = f3;
        bus.alu_res_in   = alu;
        bus.pc4_in       = pc4;
        bus.dm_rsp_valid = rv;
        bus.dm_rsp_data  = rdat;
    endtask

    // One cycle: predict from current inputs, check stall, clock, check writeback.
    task automatic step(input string tag);
        bit          commit = 0;
        bit          exp_stall = 0;
        logic        exp_en = 1'b0;
        logic [4:0]  exp_rd = '0;
        logic [31:0] exp_d = '0;
        ld_t         p;
        if (pend.size() != 0) begin
            exp_stall = !bus.dm_rsp_valid;
            if (bus.dm_rsp_valid) begin
                p = pend.pop_front();
                commit = 1;
                exp_en = p.en;
                exp_rd = p.rd;
                exp_d  = ref_load(bus.dm_rsp_data, p.f3, p.off);
            end
        end else if (bus.valid_in) begin
            exp_en = bus.rf_en_in;
            exp_rd = bus.rd_in;
            if (bus.wb_sel_in == 2'd1) begin
                if (bus.dm_rsp_valid) begin
                    commit = 1;
                    exp_d  = ref_load(bus.dm_rsp_data, bus.funct3_in, bus.alu_res_in[1:0]);
                end else begin
                    exp_stall = 1;
                    p.rd = bus.rd_in; p.en = bus.rf_en_in;
                    p.f3 = bus.funct3_in; p.off = bus.alu_res_in[1:0];
                    pend.push_back(p);
                end
            end else begin
                commit = 1;
                exp_d  = (bus.wb_sel_in == 2'd2) ? bus.pc4_in : bus.alu_res_in;
            end
        end
        #1;
        chk({tag, ":stall"}, 64'(bus.stall_out), 64'(exp_stall));
        @(posedge clk);
        #1;
        chk({tag, ":rf_en"}, 64'(bus.rf_en), 64'(commit && exp_en && exp_rd != 0));
        if (commit && exp_en && exp_rd != 0) begin
            chk({tag, ":rd"}, 64'(bus.rd), 64'(exp_rd));
            chk({tag, ":data"}, 64'(bus.wb_data), 64'(exp_d));
        end
`ifdef WB_RETIRE_CNT_EN
        chk({tag, ":cnt"}, retire_cnt, 64'(model_cnt));
`endif
        if (commit) model_cnt++;
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst:rf_en", 64'(bus.rf_en), 0);
        chk("rst:rd", 64'(bus.rd), 0);
        chk("rst:data", 64'(bus.wb_data), 0);
        chk("rst:stall", 64'(bus.stall_out), 0);
`ifdef WB_RETIRE_CNT_EN
        chk("rst:cnt", retire_cnt, 0);
`endif
        @(negedge clk) arst = 1'b0;

        // ALU op
        @(negedge clk); set_in(1, 1, 5, 0, 0, 32'h1234_5678, 0, 0, 0); step("alu");
        chk("alu:const", 64'(bus.wb_data), 64'h1234_5678);
        @(negedge clk); set_in(0, 1, 6, 0, 0, 32'hDEAD, 0, 1, 32'h55); step("idle_rsp");
        // x0 suppression via PC+4
        @(negedge clk); set_in(1, 1, 0, 2, 0, 0, 32'h104, 0, 0); step("x0");
        // LB / LBU, same-cycle response
        @(negedge clk); set_in(1, 1, 7, 1, 3'b000, 32'h3, 0, 1, 32'h80FF_7F01); step("lb");
        chk("lb:const", 64'(bus.wb_data), 64'hFFFF_FF80);
        @(negedge clk); set_in(1, 1, 7, 1, 3'b100, 32'h2, 0, 1, 32'h80FF_7F01); step("lbu");
        chk("lbu:const", 64'(bus.wb_data), 64'h0000_00FF);
        // LH with 3-cycle latency; other inputs are junk while waiting
        @(negedge clk); set_in(1, 1, 9, 1, 3'b001, 32'h2, 0, 0, 0); step("lh_issue");
        @(negedge clk); set_in(1, 1, 3, 0, 0, 32'hAAAA, 0, 0, 0); step("lh_w1");
        @(negedge clk); set_in(1, 1, 4, 2, 0, 0, 32'hBBBB, 0, 0); step("lh_w2");
        @(negedge clk); set_in(1, 1, 8, 0, 0, 32'hCCCC, 0, 1, 32'hBEEF_0000); step("lh_rsp");
        chk("lh:const", 64'(bus.wb_data), 64'hFFFF_BEEF);
        chk("lh:rd", 64'(bus.rd), 64'd9);
        // Reset while waiting abandons the load
        @(negedge clk); set_in(1, 1, 11, 1, 3'b010, 0, 0, 0, 0); step("ld_pend");
        @(negedge clk); arst = 1'b1; set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("arst:stall", 64'(bus.stall_out), 0);
        chk("arst:rf_en", 64'(bus.rf_en), 0);
        pend.delete();
        model_cnt = 0;
        @(negedge clk); arst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 32'h1111_2222); step("late_rsp");
        // Back-to-back: ALU, LW same cycle, PC+4
        @(negedge clk); set_in(1, 1, 1, 0, 0, 32'hA5A5_0001, 0, 0, 0); step("b2b_alu");
        @(negedge clk); set_in(1, 1, 2, 1, 3'b010, 32'h0, 0, 1, 32'hCAFE_F00D); step("b2b_lw");
        @(negedge clk); set_in(1, 1, 3, 2, 0, 0, 32'h0000_0200, 0, 0); step("b2b_pc4");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            set_in(1'($urandom_range(0, 3) != 0), 1'($urandom), 5'($urandom),
                   2'($urandom), 3'($urandom), $urandom, $urandom,
                   1'($urandom_range(0, 2) == 0), $urandom);
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the five-stage RV32I pipeline. It is the writer end of the register-file writeback interface that the decode stage consumes. It takes retiring instructions from the memory stage, waits on variable-latency data-memory load responses, and aligns and sign-extends load data. It drives the registered `rf_en` / `rd` / `wb_data` bundle into the register file, and asserts a pipeline stall while a load response is outstanding.

## Interface
- `DATA_WIDTH`, 32, register and datapath width; only 32 is supported.
- `clk`  in  1  pipeline clock.
- `arst`  in  1  asynchronous, active-high reset.
- `valid_in`  in  1  a retiring instruction is present this cycle.
- `rf_en_in`  in  1  instruction writes the register file.
- `rd_in`  in  5  destination register.
- `wb_sel_in`  in  2  writeback source: 0 = ALU, 1 = MEM, 2 = PC+4, 3 = reserved (treated as ALU).
- `funct3_in`  in  3  load size/sign; used only when `wb_sel_in` = 1.
- `alu_res_in`  in  DATA_WIDTH  ALU result; bits [1:0] are the load byte offset.
- `pc4_in`  in  DATA_WIDTH  PC+4.
- `dm_rsp_valid`  in  1  data-memory read response valid.
- `dm_rsp_data`  in  DATA_WIDTH  word-aligned read data.
- `stall_out`  out  1  freeze the upstream stages; combinational.
- `rf_en`  out  1  register-file write enable; registered.
- `rd`  out  5  write address; registered.
- `wb_data`  out  DATA_WIDTH  write data; registered.
- `retire_cnt`  out  64  retired-instruction count; present only with `WB_RETIRE_CNT_EN`.

## Operation
- FSM with two states: IDLE and WAIT_LD. Reset state is IDLE.
- **IDLE, `valid_in` = 0:** next cycle drives `rf_en` = 0.
- **IDLE, `valid_in` = 1, `wb_sel_in` ≠ 1:** commit next cycle.
  - `wb_data` = `alu_res_in` when `wb_sel_in` is 0 or 3; `pc4_in` when `wb_sel_in` is 2.
- **IDLE, load with `dm_rsp_valid` = 1 in the same cycle:** commit the formatted load next cycle; no stall.
- **IDLE, load with `dm_rsp_valid` = 0:**
  - Capture `rd_in`, `rf_en_in`, `funct3_in` and `alu_res_in[1:0]`.
  - Go to WAIT_LD.
  - `stall_out` is 1 in this same cycle.
- **WAIT_LD:**
  - `stall_out` = !`dm_rsp_valid`.
  - Inputs other than `dm_rsp_*` are ignored.
  - On `dm_rsp_valid`: commit using the captured fields and return to IDLE.
  - While waiting, `rf_en` = 0.
- `dm_rsp_valid` in IDLE with no load present is ignored.
- **Load formatting:** select byte/halfword from the word by offset.
  - funct3 000 = LB, sign-extended.
  - 001 = LH, sign-extended.
  - 010 = LW.
  - 100 = LBU, zero-extended.
  - 101 = LHU, zero-extended.
  - Halfwords use offset bit 1 only; bit 0 is ignored.
  - Other funct3 values yield the full word.
- `rf_en` = `rf_en_in` (or the captured value) AND (`rd` ≠ 0); writes to x0 are never emitted.
- **Reset:**
  - Outputs: `rf_en` = 0, `rd` = 0, `wb_data` = 0, `stall_out` = 0.
  - Internal state: FSM = IDLE, captured fields = 0.
  - Reset during WAIT_LD abandons the pending load; a late response is ignored.

## Timing
- Writeback latency: 1 cycle from `valid_in` (non-load, or load with a same-cycle response) to `rf_en` / `wb_data`.
- Load with a response N cycles later: committed at cycle N+1; `stall_out` is high for N cycles.
- `stall_out` has no register and depends only on state, `valid_in`, `wb_sel_in` and `dm_rsp_valid`.
- Committed outputs are held for exactly one cycle.
- The register file writes on the rising edge while `rf_en` = 1.

## Configuration
- `WB_RETIRE_CNT_EN` defined:
  - 64-bit `retire_cnt` port.
  - Resets to 0 and increments by 1 on each committed instruction (the cycle after commit, including `rd` = 0 and `rf_en_in` = 0 cases).
  - Wraps at 2^64−1 → 0.
- Undefined: no port, no counter logic.

## Test plan
- **ALU op:** `valid_in` = 1, `wb_sel_in` = 0, `rd_in` = 5, `alu_res_in` = 0x1234_5678 → next cycle `rf_en` = 1, `rd` = 5, `wb_data` = 0x1234_5678, `stall_out` = 0 throughout.
- **x0 suppression:** `rd_in` = 0, `wb_sel_in` = 2, `pc4_in` = 0x104 → `rf_en` = 0 next cycle. With the macro, `retire_cnt` goes 0 → 1.
- **LB, same-cycle response:** `dm_rsp_data` = 0x80FF_7F01, offset 3, funct3 000, `rd_in` = 7 → `wb_data` = 0xFFFF_FF80. Repeat with LBU offset 2 → 0x0000_00FF.
- **LH with 3-cycle latency:** response arrives 3 cycles later → `stall_out` = 1 for exactly 3 cycles, `rf_en` = 0 during the wait. Response 0xBEEF_0000 at offset 2 commits 0xFFFF_BEEF one cycle after the response.
- **Reset in WAIT_LD:**
  - Assert `arst` mid-wait → immediately `stall_out` = 0, `rf_en` = 0.
  - A response arriving after reset release → no write.
- **Back-to-back:** ALU, then LW with a same-cycle response, then PC+4 → three consecutive single-cycle commits with no stall.
